cmd_tx_serializer: RTL and testbench
====================================

Name: cmd_tx_serializer

Overview:
- Command-path transmitter that drives the chip's LVDS_CMD serial input, one bit per CMD_CLK cycle.
- Accepts 16-bit command frames from the command FIFO over a valid/ready handshake and shifts them out MSB first.
- Fills idle time with the sync frame and forces periodic sync frames so the chip's command decoder keeps lock.
- Sits directly upstream of the chip model; CMD connects to LVDS_CMD, and CMD_CLK is the same clock as LVDS_CMD_CLK.

Parameters:
SYNC_WORD, 16'h817E, idle/sync frame pattern
SYNC_INTERVAL, 32, max consecutive data frames before a forced sync frame; 0 disables forcing

Ports:
CMD_CLK  input  1  command clock; all logic on rising edge
RESETB  input  1  asynchronous active-low reset
EN  input  1  1 = data frames may be sent; 0 = sync only
FRAME_DATA  input  16  command frame, bit 15 transmitted first
FRAME_VALID  input  1  FRAME_DATA valid
FRAME_READY  output  1  frame accepted when FRAME_VALID & FRAME_READY
CMD  output  1  serial command bit to chip
TX_BUSY  output  1  holding register full or data frame in shifter
SYNC_PULSE  output  1  one-cycle pulse on the first bit of every sync frame

Behaviour:
- Interface: one clock, CMD_CLK; reset RESETB is asynchronous and active-low. All state clears on assertion; release is synchronous to CMD_CLK.
- Reset values:
  - shifter = SYNC_WORD, so CMD = SYNC_WORD[15] = 1.
  - bit_cnt = 0; hold_valid = 0; data_run = 0; shifter_is_data = 0.
  - FRAME_READY = 1; TX_BUSY = 0; SYNC_PULSE = 0.
- Datapath: CMD = shifter[15], driven from a register with no combinational path from inputs. Each cycle the shifter shifts left by 1 and bit_cnt increments modulo 16. The frame period is exactly 16 cycles with no gaps.
- Boundary (bit_cnt == 15): on the next edge the shifter loads a new frame and bit_cnt wraps to 0.
  - Load the data frame (from hold) when hold_valid & EN & !(SYNC_INTERVAL != 0 & data_run == SYNC_INTERVAL). In that case data_run increments, hold_valid clears, and shifter_is_data = 1.
  - Otherwise load SYNC_WORD. data_run clears and shifter_is_data = 0.
- SYNC_PULSE: high during the cycle the first bit (bit_cnt == 0) of a sync frame is on CMD. It is not asserted for the reset-loaded frame.
- Holding register: single entry.
  - FRAME_READY = !hold_valid | load_data, where load_data means the data frame is loaded at this edge.
  - Accept and load may happen on the same edge: hold keeps the new frame and hold_valid stays 1.
  - FRAME_DATA is sampled only on an accepted edge.
- Latency: an accepted frame starts on CMD at the next boundary. With the holding register empty, the first bit appears 1–16 cycles after the accept edge.
- EN = 0: the current frame completes unchanged and only sync frames follow. Hold is retained and not consumed. data_run is cleared by those sync frames. EN may toggle at any time; it is evaluated only at boundaries.
- data_run width: clog2(SYNC_INTERVAL+1). It saturates and cannot wrap.
- TX_BUSY = hold_valid | shifter_is_data.
- Reset mid-frame: the frame is aborted immediately, CMD returns to SYNC_WORD[15], and the held frame is lost.
- FRAME_VALID without FRAME_READY must be held by the source; this block never drops a presented frame.

Optional Feature:
- Macro: CMD_TX_CNT_EN.
- Defined: adds output DATA_CNT[15:0], a count of data frames loaded into the shifter. It saturates at 16'hFFFF and clears on reset.
- Undefined: the port and counter are absent and the remaining behaviour is identical.

Test Plan:
- Reset release, EN=1, FRAME_VALID=0 for 64 cycles -> CMD is 0x817E repeated 4 times; SYNC_PULSE high at cycles 16, 32, 48.
- Accept 0x5A3C at cycle 3 after reset -> FRAME_READY stays 1; CMD carries 0x5A3C in cycles 16–31 MSB first, then 0x817E; TX_BUSY 1 from cycle 4 to cycle 31.
- Back-to-back stream with FRAME_VALID held 1, SYNC_INTERVAL=4, frames 0x0001..0x0008 -> output 1,2,3,4,SYNC,5,6,7,8,SYNC with no dropped or duplicated frame.
- EN=0 with a frame held (0xBEEF) for 48 cycles -> only sync on CMD and FRAME_READY=0; after EN=1 the next boundary sends 0xBEEF.
- RESETB asserted at bit 7 of data frame 0xFFFF -> CMD=1 asynchronously, hold_valid=0, FRAME_READY=1; after release, full 0x817E frames with no residual bits.
- CMD_TX_CNT_EN defined, 5 frames sent -> DATA_CNT=5; counter forced to 0xFFFF then one more frame -> stays 0xFFFF.

Source files
------------

// File: rtl/cmd_tx_serializer.sv
// Command-path serializer: 16-bit frames shifted MSB first onto CMD, with sync-word idle fill and forced sync.
// Optional build macro CMD_TX_CNT_EN adds the DATA_CNT loaded-data-frame counter output.
module cmd_tx_serializer #(
   parameter logic [15:0] SYNC_WORD     = 16'h817E,
   parameter int unsigned SYNC_INTERVAL = 32
) (
   input  logic        CMD_CLK,
   input  logic        RESETB,
   input  logic        EN,
   input  logic [15:0] FRAME_DATA,
   input  logic        FRAME_VALID,
   output logic        FRAME_READY,
   output logic        CMD,
   output logic        TX_BUSY,
   output logic        SYNC_PULSE
`ifdef CMD_TX_CNT_EN
   ,
   output logic [15:0] DATA_CNT
`endif
);

   // A zero interval still needs a one-bit run counter even though forcing is disabled.
   localparam int unsigned      RUN_W         = (SYNC_INTERVAL == 0) ? 1 : $clog2(SYNC_INTERVAL + 1);
   localparam logic [RUN_W-1:0] RUN_LIMIT     = RUN_W'(SYNC_INTERVAL);
   localparam logic [RUN_W-1:0] RUN_MAX       = {RUN_W{1'b1}};
   localparam logic             FORCE_SYNC_EN = (SYNC_INTERVAL != 0);

   logic [15:0]      shifter_r;
   logic [3:0]       bit_cnt_r;
   logic [15:0]      hold_r;
   logic             hold_valid_r;
   logic [RUN_W-1:0] data_run_r;
   logic             shifter_is_data_r;
   logic             sync_pulse_r;

   logic boundary_s;
   logic run_limit_hit_s;
   logic load_data_s;
   logic accept_s;

   // Frame boundary decision and handshake acceptance.
   always_comb begin
      boundary_s      = (bit_cnt_r == 4'd15);
      run_limit_hit_s = FORCE_SYNC_EN && (data_run_r == RUN_LIMIT);
      load_data_s     = boundary_s && hold_valid_r && EN && !run_limit_hit_s;
      accept_s        = FRAME_VALID && (!hold_valid_r || load_data_s);
   end

   // Shifter, bit counter and sync-pulse generation; the pulse is registered so it lines up with bit 0.
   always_ff @(posedge CMD_CLK or negedge RESETB) begin
      if (!RESETB) begin
         shifter_r         <= SYNC_WORD;
         bit_cnt_r         <= 4'd0;
         shifter_is_data_r <= 1'b0;
         sync_pulse_r      <= 1'b0;
      end else begin
         bit_cnt_r <= bit_cnt_r + 4'd1;
         if (boundary_s) begin
            if (load_data_s) begin
               shifter_r         <= hold_r;
               shifter_is_data_r <= 1'b1;
               sync_pulse_r      <= 1'b0;
            end else begin
               shifter_r         <= SYNC_WORD;
               shifter_is_data_r <= 1'b0;
               sync_pulse_r      <= 1'b1;
            end
         end else begin
            shifter_r    <= {shifter_r[14:0], 1'b0};
            sync_pulse_r <= 1'b0;
         end
      end
   end

   // Consecutive data-frame run length; saturates so it can never wrap back under the limit.
   always_ff @(posedge CMD_CLK or negedge RESETB) begin
      if (!RESETB) begin
         data_run_r <= '0;
      end else if (load_data_s) begin
         if (data_run_r != RUN_MAX) begin
            data_run_r <= data_run_r + RUN_W'(1);
         end else begin
            data_run_r <= data_run_r;
         end
      end else if (boundary_s) begin
         data_run_r <= '0;
      end else begin
         data_run_r <= data_run_r;
      end
   end

   // Single-entry holding register; an accept on a load edge keeps the entry occupied.
   always_ff @(posedge CMD_CLK or negedge RESETB) begin
      if (!RESETB) begin
         hold_r       <= 16'h0000;
         hold_valid_r <= 1'b0;
      end else if (accept_s) begin
         hold_r       <= FRAME_DATA;
         hold_valid_r <= 1'b1;
      end else if (load_data_s) begin
         hold_valid_r <= 1'b0;
      end else begin
         hold_valid_r <= hold_valid_r;
      end
   end

`ifdef CMD_TX_CNT_EN
   logic [15:0] data_cnt_r;

   // Saturating count of data frames loaded into the shifter.
   always_ff @(posedge CMD_CLK or negedge RESETB) begin
      if (!RESETB) begin
         data_cnt_r <= 16'h0000;
      end else if (load_data_s && (data_cnt_r != 16'hFFFF)) begin
         data_cnt_r <= data_cnt_r + 16'd1;
      end else begin
         data_cnt_r <= data_cnt_r;
      end
   end

   assign DATA_CNT = data_cnt_r;
`endif

   assign CMD         = shifter_r[15];
   assign SYNC_PULSE  = sync_pulse_r;
   assign TX_BUSY     = hold_valid_r | shifter_is_data_r;
   assign FRAME_READY = !hold_valid_r | load_data_s;

endmodule

// File: tb/tb_cmd_tx_serializer.sv
// Directed bench for cmd_tx_serializer: idle sync, single frame, streaming with forced sync, EN gating, mid-frame reset.
module tb_cmd_tx_serializer;

   logic        CMD_CLK = 1'b0;
   logic        RESETB = 1'b0;
   logic        EN = 1'b1;
   logic [15:0] FRAME_DATA = 16'h0000;
   logic        FRAME_VALID = 1'b0;
   logic        FRAME_READY;
   logic        CMD;
   logic        TX_BUSY;
   logic        SYNC_PULSE;
`ifdef CMD_TX_CNT_EN
   logic [15:0] DATA_CNT;
`endif

   cmd_tx_serializer #(
      .SYNC_WORD     (16'h817E),
      .SYNC_INTERVAL (4)
   ) dut (
      .CMD_CLK     (CMD_CLK),
      .RESETB      (RESETB),
      .EN          (EN),
      .FRAME_DATA  (FRAME_DATA),
      .FRAME_VALID (FRAME_VALID),
      .FRAME_READY (FRAME_READY),
      .CMD         (CMD),
      .TX_BUSY     (TX_BUSY),
      .SYNC_PULSE  (SYNC_PULSE)
`ifdef CMD_TX_CNT_EN
      ,
      .DATA_CNT    (DATA_CNT)
`endif
   );

   always #5 CMD_CLK = ~CMD_CLK;

   int n_total = 0;
   int n_pass  = 0;
   int cyc_n   = 0;
   logic [255:0] cmd_v, rdy_v, busy_v, sp_v;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Hold reset for two cycles and release on a falling edge; cycle 0 starts at release.
   task automatic do_reset();
      RESETB      = 1'b0;
      FRAME_VALID = 1'b0;
      EN          = 1'b1;
      repeat (2) @(negedge CMD_CLK);
      RESETB = 1'b1;
      cyc_n  = 0;
      cmd_v  = '0;
      rdy_v  = '0;
      busy_v = '0;
      sp_v   = '0;
   endtask

   // Drive one cycle's inputs at the falling edge, sample outputs 1 time unit later.
   task automatic cyc(input logic fv, input logic [15:0] fd, input logic en);
      FRAME_VALID = fv;
      FRAME_DATA  = fd;
      EN          = en;
      #1;
      cmd_v[cyc_n]  = CMD;
      rdy_v[cyc_n]  = FRAME_READY;
      busy_v[cyc_n] = TX_BUSY;
      sp_v[cyc_n]   = SYNC_PULSE;
      cyc_n++;
      @(negedge CMD_CLK);
   endtask

   function automatic logic [15:0] word_at(input int k);
      logic [15:0] w;
      for (int i = 0; i < 16; i++) begin
         w[15-i] = cmd_v[16*k + i];
      end
      return w;
   endfunction

   logic [15:0] exp3 [11];
   int idx;
   logic fv3;

   initial begin
      exp3 = '{16'h817E, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h817E,
               16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h817E};

      // Idle: sync fill only.
      do_reset();
      for (int c = 0; c < 64; c++) cyc(1'b0, 16'h0000, 1'b1);
      check("rst_cmd", 64'(cmd_v[0]), 64'd1);
      check("rst_ready", 64'(rdy_v[0]), 64'd1);
      check("rst_busy", 64'(busy_v[0]), 64'd0);
      check("rst_sync_pulse", 64'(sp_v[0]), 64'd0);
      for (int k = 0; k < 4; k++) check($sformatf("idle_word%0d", k), 64'(word_at(k)), 64'h817E);
      check("idle_sync_pulses", sp_v[63:0], 64'h0001_0001_0001_0000);

      // Single frame accepted at cycle 3.
      do_reset();
      for (int c = 0; c < 64; c++) cyc(c == 3, 16'h5A3C, 1'b1);
      check("single_ready", 64'(rdy_v[3]), 64'd1);
      check("single_word1", 64'(word_at(1)), 64'h5A3C);
      check("single_word2", 64'(word_at(2)), 64'h817E);
      check("single_busy", busy_v[63:0], 64'h0000_0000_FFFF_FFF0);
      check("single_sync_pulses", sp_v[63:0], 64'h0001_0001_0000_0000);

      // Back-to-back stream with VALID held; sync forced after every 4 data frames.
      do_reset();
      idx = 0;
      for (int c = 0; c < 176; c++) begin
         fv3 = (idx < 8);
         cyc(fv3, 16'(idx + 1), 1'b1);
         if (fv3 && rdy_v[c]) idx++;
      end
      for (int k = 0; k < 11; k++) check($sformatf("stream_word%0d", k), 64'(word_at(k)), 64'(exp3[k]));
      check("stream_accepted", 64'(idx), 64'd8);
`ifdef CMD_TX_CNT_EN
      check("data_cnt", 64'(DATA_CNT), 64'd8);
`endif

      // EN low with a held frame: sync only, frame kept until EN returns.
      do_reset();
      for (int c = 0; c < 80; c++) cyc(c == 0, 16'hBEEF, c >= 48);
      check("en0_accept_ready", 64'(rdy_v[0]), 64'd1);
      check("en0_ready_low", 64'(rdy_v[47:1]), 64'd0);
      check("en0_busy", 64'(busy_v[47]), 64'd1);
      for (int k = 0; k < 4; k++) check($sformatf("en0_word%0d", k), 64'(word_at(k)), 64'h817E);
      check("en1_word4", 64'(word_at(4)), 64'hBEEF);

      // Reset at bit 7 of data frame 0xFFFF with a second frame held.
      do_reset();
      for (int c = 0; c < 23; c++) cyc((c == 0) || (c == 16), (c == 0) ? 16'hFFFF : 16'h1234, 1'b1);
      check("pre_rst_ready", 64'(rdy_v[16]), 64'd1);
      check("pre_rst_busy", 64'(busy_v[22]), 64'd1);
      #2;
      RESETB = 1'b0;
      #1;
      check("async_rst_cmd", 64'(CMD), 64'd1);
      check("async_rst_ready", 64'(FRAME_READY), 64'd1);
      check("async_rst_busy", 64'(TX_BUSY), 64'd0);
      @(negedge CMD_CLK);
      do_reset();
      for (int c = 0; c < 48; c++) cyc(1'b0, 16'h0000, 1'b1);
      for (int k = 0; k < 3; k++) check($sformatf("post_rst_word%0d", k), 64'(word_at(k)), 64'h817E);
      check("post_rst_busy", busy_v[63:0], 64'd0);
      check("post_rst_sync_pulses", sp_v[63:0], 64'h0000_0001_0001_0000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
